// File: rtl/req_gnt_pkg.sv
// Shared types and default configuration for the req/gnt initiator.
// The optional timeout-and-retry policy is enabled by defining REQ_GNT_TIMEOUT_EN.
package req_gnt_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_GAP
    } req_gnt_state_t;

    // What the GAP phase leads into once it has run its course.
    typedef enum logic {
        TAG_FINISH,
        TAG_REREQ
    } req_gnt_tag_t;

    localparam int DEF_MAX_WAIT  = 4;
    localparam int DEF_GAP       = 1;
    localparam int DEF_MAX_RETRY = 2;

endpackage

// File: rtl/req_gnt_wait_timer.sv
// Loadable saturating down-counter; expired is high while the count sits at zero.
// Loading N makes expired rise on the (N+1)-th following edge.
module req_gnt_wait_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign expired = (count_reg == '0);

endmodule

// File: rtl/req_gnt_initiator.sv
// Requesting side of the single-bit req/gnt handshake with an enforced idle gap.
// Define REQ_GNT_TIMEOUT_EN to bound each request by MAX_WAIT cycles with MAX_RETRY re-requests.
module req_gnt_initiator
    import req_gnt_pkg::*;
#(
    parameter int MAX_WAIT  = DEF_MAX_WAIT,
    parameter int GAP       = DEF_GAP,
    parameter int MAX_RETRY = DEF_MAX_RETRY,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    output logic             req,
    input  logic             gnt,
    output logic             done,
    output logic             timeout,
    output logic             busy,
    output logic [CNT_W-1:0] xfer_cnt
);

    localparam int GAP_W = $clog2(GAP + 1);

    req_gnt_state_t   state_reg;
    req_gnt_tag_t     tag_reg;
    logic             req_reg;
    logic             done_reg;
    logic [CNT_W-1:0] xfer_cnt_reg;

    logic in_idle, in_req, in_gap;
    logic gap_load, gap_expired, wait_expiry;

    assign in_idle = (state_reg == S_IDLE);
    assign in_req  = (state_reg == S_REQ);
    assign in_gap  = (state_reg == S_GAP);

`ifdef REQ_GNT_TIMEOUT_EN
    localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    logic [RETRY_W-1:0] retry_reg;
    logic               timeout_reg;
    logic               wait_load, wait_expired;

    // Reload on every entry into REQ, both fresh commands and re-requests.
    assign wait_load = (in_idle & cmd_valid) | (in_gap & gap_expired & (tag_reg == TAG_REREQ));

    req_gnt_wait_timer #(.W(WAIT_W)) u_wait_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (wait_load),
        .load_val (WAIT_W'(MAX_WAIT - 1)),
        .expired  (wait_expired)
    );

    assign wait_expiry = in_req & wait_expired;
    assign timeout     = timeout_reg;
`else
    localparam int UNUSED_CFG = MAX_WAIT + MAX_RETRY;

    assign wait_expiry = 1'b0;
    assign timeout     = 1'b0;
`endif

    // Grant and expiry both end the REQ phase, so either one starts the gap.
    assign gap_load = in_req & (gnt | wait_expiry);

    req_gnt_wait_timer #(.W(GAP_W)) u_gap_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (gap_load),
        .load_val (GAP_W'(GAP - 1)),
        .expired  (gap_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            tag_reg      <= TAG_FINISH;
            req_reg      <= 1'b0;
            done_reg     <= 1'b0;
            xfer_cnt_reg <= '0;
`ifdef REQ_GNT_TIMEOUT_EN
            retry_reg    <= '0;
            timeout_reg  <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
`ifdef REQ_GNT_TIMEOUT_EN
            timeout_reg <= 1'b0;
`endif
            case (state_reg)
                S_IDLE: begin
                    if (cmd_valid) begin
                        state_reg <= S_REQ;
                        req_reg   <= 1'b1;
`ifdef REQ_GNT_TIMEOUT_EN
                        retry_reg <= '0;
`endif
                    end
                end
                S_REQ: begin
                    // Grant is checked first so it wins a same-cycle expiry.
                    if (gnt) begin
                        done_reg     <= 1'b1;
                        xfer_cnt_reg <= xfer_cnt_reg + 1'b1;
                        req_reg      <= 1'b0;
                        tag_reg      <= TAG_FINISH;
                        state_reg    <= S_GAP;
                    end else if (wait_expiry) begin
                        req_reg   <= 1'b0;
                        state_reg <= S_GAP;
`ifdef REQ_GNT_TIMEOUT_EN
                        if (retry_reg < RETRY_W'(MAX_RETRY)) begin
                            retry_reg <= retry_reg + 1'b1;
                            tag_reg   <= TAG_REREQ;
                        end else begin
                            timeout_reg <= 1'b1;
                            tag_reg     <= TAG_FINISH;
                        end
`else
                        tag_reg <= TAG_FINISH;
`endif
                    end
                end
                S_GAP: begin
                    if (gap_expired) begin
                        if (tag_reg == TAG_REREQ) begin
                            state_reg <= S_REQ;
                            req_reg   <= 1'b1;
                        end else begin
                            state_reg <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    req_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign req       = req_reg;
    assign done      = done_reg;
    assign xfer_cnt  = xfer_cnt_reg;
    assign cmd_ready = in_idle;
    assign busy      = ~in_idle;

endmodule
